// File: rtl/pipe_stage_chain.sv
// Elastic pipeline register: DEPTH valid/data stages with backpressure, bubble
// collapsing, flush, occupancy count and a zero flag on the output register.
module pipe_stage_chain #(
  parameter int unsigned      WIDTH     = 16,
  parameter int unsigned      DEPTH     = 2,
  parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         flush,
  input  logic                         in_valid,
  output logic                         in_ready,
  input  logic [WIDTH-1:0]             in_data,
  output logic                         out_valid,
  input  logic                         out_ready,
  output logic [WIDTH-1:0]             out_data,
  output logic                         out_zero,
  output logic [$clog2(DEPTH+1)-1:0]   occupancy
);

  localparam int unsigned OCC_W = $clog2(DEPTH + 1);

  logic [DEPTH-1:0] v_q;
  logic [DEPTH-1:0] v_d;
  logic [WIDTH-1:0] d_q [DEPTH];
  logic [WIDTH-1:0] d_d [DEPTH];
  logic [DEPTH-1:0] adv;
  logic [DEPTH-1:0] load;
  logic             in_fire;
  logic [OCC_W-1:0] occ;

  // Ready chain: walks from the output side back to the input side.
  always_comb begin
    adv  = '0;
    load = '0;
    adv[DEPTH-1] = v_q[DEPTH-1] && out_ready;
    for (int k = int'(DEPTH) - 2; k >= 0; k--) begin
      adv[k] = v_q[k] && (!v_q[k+1] || adv[k+1]);
    end
    for (int k = 0; k < int'(DEPTH); k++) begin
      load[k] = !v_q[k] || adv[k];
    end
    in_ready = load[0] && !flush && !reset;
  end

  // Next state; data registers only capture real items, never bubbles.
  always_comb begin
    v_d     = v_q;
    d_d     = d_q;
    in_fire = in_valid && in_ready;
    if (load[0]) begin
      v_d[0] = in_fire;
      if (in_fire) d_d[0] = in_data;
    end
    for (int k = 1; k < int'(DEPTH); k++) begin
      if (load[k]) begin
        v_d[k] = adv[k-1];
        if (adv[k-1]) d_d[k] = d_q[k-1];
      end
    end
    if (flush) begin
      v_d = '0;
      d_d = d_q;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      v_q <= '0;
      for (int k = 0; k < int'(DEPTH); k++) d_q[k] <= RESET_VAL;
    end else begin
      v_q <= v_d;
      d_q <= d_d;
    end
  end

  always_comb begin
    occ = '0;
    for (int k = 0; k < int'(DEPTH); k++) occ = occ + OCC_W'(v_q[k]);
  end

  assign occupancy = occ;
  assign out_valid = v_q[DEPTH-1];
  assign out_data  = d_q[DEPTH-1];
  assign out_zero  = v_q[DEPTH-1] && (d_q[DEPTH-1] == '0);

endmodule

// File: tb/tb_pipe_stage_chain.sv
// Bench for pipe_stage_chain: three instances (DEPTH 2/3/4) driven by directed
// scenarios and random traffic, checked against an item-position queue model.
module tb_pipe_stage_chain;

  localparam int unsigned W = 16;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic         rst [3];
  logic         fl  [3];
  logic         iv  [3];
  logic         ordy[3];
  logic [W-1:0] din [3];
  logic         ir  [3];
  logic         ov  [3];
  logic         oz  [3];
  logic [W-1:0] dout[3];
  logic [1:0]   occ0;
  logic [1:0]   occ1;
  logic [2:0]   occ2;

  pipe_stage_chain #(.WIDTH(W), .DEPTH(2), .RESET_VAL(16'hFFFF)) u_d2 (
    .clk(clk), .reset(rst[0]), .flush(fl[0]), .in_valid(iv[0]), .in_ready(ir[0]),
    .in_data(din[0]), .out_valid(ov[0]), .out_ready(ordy[0]), .out_data(dout[0]),
    .out_zero(oz[0]), .occupancy(occ0));
  pipe_stage_chain #(.WIDTH(W), .DEPTH(3), .RESET_VAL(16'h0000)) u_d3 (
    .clk(clk), .reset(rst[1]), .flush(fl[1]), .in_valid(iv[1]), .in_ready(ir[1]),
    .in_data(din[1]), .out_valid(ov[1]), .out_ready(ordy[1]), .out_data(dout[1]),
    .out_zero(oz[1]), .occupancy(occ1));
  pipe_stage_chain #(.WIDTH(W), .DEPTH(4), .RESET_VAL(16'h1234)) u_d4 (
    .clk(clk), .reset(rst[2]), .flush(fl[2]), .in_valid(iv[2]), .in_ready(ir[2]),
    .in_data(din[2]), .out_valid(ov[2]), .out_ready(ordy[2]), .out_data(dout[2]),
    .out_zero(oz[2]), .occupancy(occ2));

  int checks   = 0;
  int failures = 0;

  // Model: in-flight items in FIFO order, each tagged with its stage index.
  typedef struct {
    logic [W-1:0] data;
    int           pos;
  } item_t;
  item_t        q[$];
  int           md;
  logic [W-1:0] m_last;

  function automatic int depth_of(input int u);
    return u + 2;
  endfunction

  function automatic logic [W-1:0] rval_of(input int u);
    case (u)
      0:       return 16'hFFFF;
      1:       return 16'h0000;
      default: return 16'h1234;
    endcase
  endfunction

  function automatic int occ_of(input int u);
    case (u)
      0:       return int'(occ0);
      1:       return int'(occ1);
      default: return int'(occ2);
    endcase
  endfunction

  function automatic logic m_ov();
    return (q.size() > 0) && (q[0].pos == md - 1);
  endfunction

  function automatic logic m_ready(input logic r, input logic f, input logic o);
    return !r && !f && ((q.size() < md) || o);
  endfunction

  task automatic drive(input int u, input logic r, input logic f, input logic v,
                       input logic [W-1:0] d, input logic o);
    rst[u] = r; fl[u] = f; iv[u] = v; din[u] = d; ordy[u] = o;
    #1;
  endtask

  // One clock edge for instance u, advancing the model the same way.
  task automatic tick(input int u);
    logic  r, f, acc, cons;
    int    ahead;
    item_t nq[$];
    r    = rst[u];
    f    = fl[u];
    acc  = iv[u] && m_ready(rst[u], fl[u], ordy[u]);
    cons = m_ov() && ordy[u];
    @(posedge clk);
    if (r) begin
      q.delete();
      m_last = rval_of(u);
    end else begin
      ahead = md;
      foreach (q[i]) begin
        item_t it;
        it = q[i];
        if (it.pos == md - 1) begin
          if (!cons) begin
            nq.push_back(it);
            ahead = it.pos;
          end
        end else begin
          if (it.pos + 1 < ahead) it.pos = it.pos + 1;
          if (it.pos == md - 1 && !f) m_last = it.data;
          nq.push_back(it);
          ahead = it.pos;
        end
      end
      if (f) nq.delete();
      else if (acc) begin
        if (md == 1) m_last = din[u];
        nq.push_back('{data: din[u], pos: 0});
      end
      q = nq;
    end
    @(negedge clk);
  endtask

  task automatic test_reset(input int u);
    md = depth_of(u);
    drive(u, 1'b1, 1'b0, 1'b1, 16'h5A5A, 1'b1);
    checks++;
    if (ir[u] !== 1'b0) begin failures++; $display("FAIL reset_in_ready u=%0d got=%b exp=0", u, ir[u]); end
    tick(u);
    drive(u, 1'b0, 1'b0, 1'b0, '0, 1'b0);
    checks++;
    if (occ_of(u) != 0) begin failures++; $display("FAIL reset_occ u=%0d got=%0d exp=0", u, occ_of(u)); end
    checks++;
    if (ov[u] !== 1'b0 || oz[u] !== 1'b0) begin failures++; $display("FAIL reset_valid u=%0d ov=%b oz=%b exp=0/0", u, ov[u], oz[u]); end
    checks++;
    if (dout[u] !== rval_of(u)) begin failures++; $display("FAIL reset_data u=%0d got=%h exp=%h", u, dout[u], rval_of(u)); end
  endtask

  task automatic test_stream();
    logic [W-1:0] got[$];
    test_reset(0);
    for (int c = 0; c < 11; c++) begin
      drive(0, 1'b0, 1'b0, c < 8, W'(c + 1), 1'b1);
      if (c < 8) begin
        checks++;
        if (ir[0] !== 1'b1) begin failures++; $display("FAIL stream_ready c=%0d got=%b exp=1", c, ir[0]); end
      end
      checks++;
      if (ov[0] !== m_ov()) begin failures++; $display("FAIL stream_valid c=%0d got=%b exp=%b", c, ov[0], m_ov()); end
      if (ov[0] === 1'b1) got.push_back(dout[0]);
      tick(0);
    end
    checks++;
    if (got.size() != 8) begin failures++; $display("FAIL stream_count got=%0d exp=8", got.size()); end
    foreach (got[i]) begin
      checks++;
      if (got[i] !== W'(i + 1)) begin failures++; $display("FAIL stream_order i=%0d got=%h exp=%h", i, got[i], W'(i + 1)); end
    end
  endtask

  task automatic test_backpressure();
    logic [W-1:0] got[$];
    logic [W-1:0] vals[4];
    int           idx;
    vals = '{16'h00A1, 16'h00A2, 16'h00A3, 16'h00A4};
    test_reset(1);
    for (int c = 0; c < 4; c++) begin
      drive(1, 1'b0, 1'b0, 1'b1, vals[c], 1'b0);
      checks++;
      if (ir[1] !== (c < 3)) begin failures++; $display("FAIL bp_ready c=%0d got=%b exp=%b", c, ir[1], c < 3); end
      tick(1);
      checks++;
      if (occ_of(1) != ((c < 3) ? c + 1 : 3)) begin failures++; $display("FAIL bp_occ c=%0d got=%0d exp=%0d", c, occ_of(1), (c < 3) ? c + 1 : 3); end
    end
    idx = 3;
    for (int c = 0; c < 12; c++) begin
      drive(1, 1'b0, 1'b0, idx < 4, (idx < 4) ? vals[3] : 16'h0, 1'b1);
      if (ov[1] === 1'b1) got.push_back(dout[1]);
      if (iv[1] && ir[1]) idx++;
      tick(1);
    end
    checks++;
    if (got.size() != 4) begin failures++; $display("FAIL bp_count got=%0d exp=4", got.size()); end
    foreach (got[i]) begin
      checks++;
      if (i < 4 && got[i] !== vals[i]) begin failures++; $display("FAIL bp_order i=%0d got=%h exp=%h", i, got[i], vals[i]); end
    end
  endtask

  task automatic test_bubble();
    test_reset(2);
    drive(2, 1'b0, 1'b0, 1'b1, 16'h0011, 1'b0);
    tick(2);
    for (int c = 0; c < 3; c++) begin
      drive(2, 1'b0, 1'b0, 1'b0, 16'h0, 1'b0);
      checks++;
      if (ov[2] !== 1'b0) begin failures++; $display("FAIL bubble_early c=%0d got=%b exp=0", c, ov[2]); end
      tick(2);
    end
    drive(2, 1'b0, 1'b0, 1'b1, 16'h0022, 1'b0);
    checks++;
    if (ov[2] !== 1'b1 || dout[2] !== 16'h0011 || occ_of(2) != 1) begin
      failures++; $display("FAIL bubble_arrive ov=%b data=%h occ=%0d exp=1/0011/1", ov[2], dout[2], occ_of(2));
    end
    checks++;
    if (ir[2] !== 1'b1) begin failures++; $display("FAIL bubble_ready got=%b exp=1", ir[2]); end
    tick(2);
    for (int c = 0; c < 3; c++) begin
      drive(2, 1'b0, 1'b0, 1'b0, 16'h0, 1'b0);
      checks++;
      if (ir[2] !== 1'b1 || occ_of(2) != 2) begin failures++; $display("FAIL bubble_hold c=%0d ready=%b occ=%0d exp=1/2", c, ir[2], occ_of(2)); end
      tick(2);
    end
    for (int c = 0; c < 3; c++) begin
      drive(2, 1'b0, 1'b0, 1'b0, 16'h0, 1'b1);
      checks++;
      if (ov[2] !== m_ov() || (m_ov() && dout[2] !== q[0].data)) begin
        failures++; $display("FAIL bubble_drain c=%0d ov=%b data=%h exp_ov=%b", c, ov[2], dout[2], m_ov());
      end
      tick(2);
    end
  endtask

  task automatic test_flush();
    logic [W-1:0] got[$];
    test_reset(0);
    drive(0, 1'b0, 1'b0, 1'b1, 16'h0055, 1'b0); tick(0);
    drive(0, 1'b0, 1'b0, 1'b1, 16'h0066, 1'b0); tick(0);
    drive(0, 1'b0, 1'b0, 1'b1, 16'h0099, 1'b0);
    checks++;
    if (occ_of(0) != 2 || ir[0] !== 1'b0) begin failures++; $display("FAIL flush_full occ=%0d ready=%b exp=2/0", occ_of(0), ir[0]); end
    drive(0, 1'b0, 1'b1, 1'b1, 16'h0099, 1'b1);
    checks++;
    if (ir[0] !== 1'b0 || ov[0] !== 1'b1) begin failures++; $display("FAIL flush_cycle ready=%b ov=%b exp=0/1", ir[0], ov[0]); end
    tick(0);
    drive(0, 1'b0, 1'b0, 1'b0, 16'h0, 1'b1);
    checks++;
    if (occ_of(0) != 0 || ov[0] !== 1'b0) begin failures++; $display("FAIL flush_after occ=%0d ov=%b exp=0/0", occ_of(0), ov[0]); end
    drive(0, 1'b0, 1'b0, 1'b1, 16'h0077, 1'b1); tick(0);
    for (int c = 0; c < 4; c++) begin
      drive(0, 1'b0, 1'b0, 1'b0, 16'h0, 1'b1);
      if (ov[0] === 1'b1) got.push_back(dout[0]);
      tick(0);
    end
    checks++;
    if (got.size() != 1 || got[0] !== 16'h0077) begin failures++; $display("FAIL flush_refill count=%0d first=%h exp=1/0077", got.size(), (got.size() > 0) ? got[0] : 16'h0); end
  endtask

  task automatic test_zero();
    test_reset(0);
    drive(0, 1'b0, 1'b0, 1'b1, 16'h0000, 1'b0); tick(0);
    drive(0, 1'b0, 1'b0, 1'b1, 16'h0003, 1'b0);
    checks++;
    if (oz[0] !== 1'b0) begin failures++; $display("FAIL zero_notyet got=%b exp=0", oz[0]); end
    tick(0);
    drive(0, 1'b0, 1'b0, 1'b0, 16'h0, 1'b1);
    checks++;
    if (oz[0] !== 1'b1 || ov[0] !== 1'b1) begin failures++; $display("FAIL zero_at_out oz=%b ov=%b exp=1/1", oz[0], ov[0]); end
    tick(0);
    drive(0, 1'b0, 1'b0, 1'b0, 16'h0, 1'b1);
    checks++;
    if (oz[0] !== 1'b0 || dout[0] !== 16'h0003) begin failures++; $display("FAIL zero_nonzero oz=%b data=%h exp=0/0003", oz[0], dout[0]); end
    tick(0);
    drive(0, 1'b0, 1'b0, 1'b0, 16'h0, 1'b1);
    checks++;
    if (oz[0] !== 1'b0 || ov[0] !== 1'b0) begin failures++; $display("FAIL zero_empty oz=%b ov=%b exp=0/0", oz[0], ov[0]); end
  endtask

  task automatic test_reset_midstream();
    test_reset(0);
    drive(0, 1'b0, 1'b0, 1'b1, 16'h0101, 1'b0); tick(0);
    drive(0, 1'b0, 1'b0, 1'b1, 16'h0202, 1'b0); tick(0);
    drive(0, 1'b1, 1'b1, 1'b1, 16'h0303, 1'b1);
    checks++;
    if (ir[0] !== 1'b0) begin failures++; $display("FAIL rstmid_ready got=%b exp=0", ir[0]); end
    tick(0);
    drive(0, 1'b0, 1'b0, 1'b1, 16'h0042, 1'b0);
    checks++;
    if (occ_of(0) != 0 || ov[0] !== 1'b0 || dout[0] !== 16'hFFFF) begin
      failures++; $display("FAIL rstmid_state occ=%0d ov=%b data=%h exp=0/0/ffff", occ_of(0), ov[0], dout[0]);
    end
    checks++;
    if (ir[0] !== 1'b1) begin failures++; $display("FAIL rstmid_accept got=%b exp=1", ir[0]); end
    tick(0);
    drive(0, 1'b0, 1'b0, 1'b0, 16'h0, 1'b0);
    checks++;
    if (occ_of(0) != 1) begin failures++; $display("FAIL rstmid_occ got=%0d exp=1", occ_of(0)); end
  endtask

  task automatic test_random(input int u);
    logic r, f, v, o;
    test_reset(u);
    for (int c = 0; c < 400; c++) begin
      r = ($urandom_range(0, 63) == 0);
      f = ($urandom_range(0, 15) == 0);
      v = ($urandom_range(0, 9) < 7);
      o = ($urandom_range(0, 9) < 6);
      drive(u, r, f, v, W'($urandom_range(0, 7) == 0 ? 0 : $urandom), o);
      checks++;
      if (ir[u] !== m_ready(r, f, o)) begin failures++; $display("FAIL rnd_ready u=%0d c=%0d got=%b exp=%b", u, c, ir[u], m_ready(r, f, o)); end
      checks++;
      if (ov[u] !== m_ov()) begin failures++; $display("FAIL rnd_valid u=%0d c=%0d got=%b exp=%b", u, c, ov[u], m_ov()); end
      checks++;
      if (dout[u] !== m_last) begin failures++; $display("FAIL rnd_data u=%0d c=%0d got=%h exp=%h", u, c, dout[u], m_last); end
      checks++;
      if (oz[u] !== (m_ov() && m_last == '0)) begin failures++; $display("FAIL rnd_zero u=%0d c=%0d got=%b exp=%b", u, c, oz[u], m_ov() && m_last == '0); end
      checks++;
      if (occ_of(u) != q.size()) begin failures++; $display("FAIL rnd_occ u=%0d c=%0d got=%0d exp=%0d", u, c, occ_of(u), q.size()); end
      tick(u);
    end
  endtask

  initial begin
    for (int i = 0; i < 3; i++) begin
      rst[i] = 1'b1; fl[i] = 1'b0; iv[i] = 1'b0; ordy[i] = 1'b0; din[i] = '0;
    end
    repeat (2) @(negedge clk);
    for (int i = 0; i < 3; i++) rst[i] = 1'b0;
    test_reset(0);
    test_reset(1);
    test_reset(2);
    test_stream();
    test_backpressure();
    test_bubble();
    test_flush();
    test_zero();
    test_reset_midstream();
    for (int u = 0; u < 3; u++) test_random(u);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
